// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO helpers: width derivation, parameter checks, operation encoding
package fifo_pkg;

   localparam int FIFO_MIN_DEPTH = 4;

   // Accepted-operation encoding, bit 1 = write accepted, bit 0 = read accepted.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int fifo_clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   function automatic bit fifo_is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit fifo_thresh_ok(input int depth, input int ae, input int af);
      return (ae >= 0) && (ae < af) && (af <= depth);
   endfunction

endpackage

// File: rtl/fifo_mem_1w1r.sv
// rtl/fifo_mem_1w1r.sv - DEPTH x WIDTH register array, synchronous write, asynchronous read
//
// Ports:
//   clock  - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data, mem[raddr]
//
// Contents are deliberately not reset so the array can map onto MLAB/LUTRAM.
module fifo_mem_1w1r
   import fifo_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 128,
   localparam int AW   = fifo_clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param_show_ahead.sv
// rtl/fifo_param_show_ahead.sv - parametrised single-clock show-ahead FIFO with error flags and watermark
//
// Ports:
//   clock, aclr_n           - rising-edge clock, asynchronous active-low reset
//   sclr                    - synchronous flush (pointers, count, error flags, watermark)
//   data, wrreq             - write data and request
//   rdreq                   - read acknowledge, pops the word shown on q
//   clr_err                 - clears overflow/underflow, reloads peak_usedw
//   q                       - head word, valid whenever empty = 0
//   usedw                   - occupancy 0..DEPTH
//   full, empty             - usedw == DEPTH / usedw == 0
//   almost_full/empty       - usedw >= AF_THRESH / usedw <= AE_THRESH
//   overflow, underflow     - sticky dropped-write / ignored-read flags
//   peak_usedw              - highest occupancy since reset or clr_err
module fifo_param_show_ahead
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int DEPTH     = 128,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   localparam int AW       = fifo_clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             aclr_n,
   input  logic             sclr,
   input  logic [WIDTH-1:0] data,
   input  logic             wrreq,
   input  logic             rdreq,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [AW:0]      usedw,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow,
   output logic [AW:0]      peak_usedw
);

   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param_show_ahead: WIDTH must be at least 1");
   end
   if (!fifo_is_pow2(DEPTH) || (DEPTH < FIFO_MIN_DEPTH)) begin : g_bad_depth
      $error("fifo_param_show_ahead: DEPTH must be a power of two and at least 4");
   end
   if (!fifo_thresh_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
      $error("fifo_param_show_ahead: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AF_W    = (AW + 1)'(AF_THRESH);
   localparam logic [AW:0] AE_W    = (AW + 1)'(AE_THRESH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   usedw_q, usedw_d;
   logic [AW:0]   peak_q, peak_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic          full_w, empty_w;
   logic          wr_acc, rd_acc, mem_we;
   fifo_op_e      op;

   // Status is derived from the registered count only, so every flag is
   // glitch-free relative to the clock and settles one edge after an operation.
   assign full_w  = (usedw_q == DEPTH_W);
   assign empty_w = (usedw_q == '0);

   always_comb begin
      rd_acc     = rdreq & ~empty_w;
      // A full FIFO still takes a write when the head is popped in the same cycle;
      // the write lands in the slot being vacated.
      wr_acc     = wrreq & (~full_w | rd_acc);
      op         = fifo_op_e'({wr_acc, rd_acc});

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      usedw_d    = usedw_q;
      peak_d     = peak_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      mem_we     = 1'b0;

      if (sclr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usedw_d  = '0;
         peak_d   = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         mem_we = wr_acc;
         case (op)
            OP_WRITE: begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               usedw_d  = usedw_q + 1'b1;
            end
            OP_READ: begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               usedw_d  = usedw_q - 1'b1;
            end
            OP_BOTH: begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: begin
            end
         endcase

         // A fresh error in the clearing cycle still registers, so no event is lost.
         ovf_d = (ovf_q & ~clr_err) | (wrreq & ~wr_acc);
         udf_d = (udf_q & ~clr_err) | (rdreq & empty_w);

         if (clr_err) begin
            peak_d = usedw_d;
         end else if (usedw_d > peak_q) begin
            peak_d = usedw_d;
         end
      end
   end

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         peak_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         peak_q   <= peak_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem_1w1r #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock (clock),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (data),
      .raddr (rd_ptr_q),
      .rdata (q)
   );

   assign usedw        = usedw_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (usedw_q >= AF_W);
   assign almost_empty = (usedw_q <= AE_W);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign peak_usedw   = peak_q;

endmodule
